mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
Parametrised modulo counter with synchronous load, up/down counting and cascade carry/borrow. It is the general digit counter for the alarm clock: seconds, minutes, hours and AM/PM digits, plus the set-mode digits. Instances chain through CARRY/BORROW into the next digit's Enable. Replaces the fixed-range per-digit counters.

Parameters:
WIDTH, 4, count register width in bits
MIN, 0, lowest count value (wrap target when counting up)
MAX, 9, highest count value (wrap target when counting down); requires MIN <= MAX <= 2^WIDTH-1
RESET_VAL, 0, value loaded on Clr; requires MIN <= RESET_VAL <= MAX

Ports:
Clk  input  1  rising-edge clock
Clr  input  1  asynchronous active-low reset
Enable  input  1  qualifies LD, Up and Down; cascade input from the previous stage's CARRY/BORROW
LD  input  1  synchronous load request
LD_VAL  input  WIDTH  load value
Up  input  1  count up
Down  input  1  count down
COUNT  output  WIDTH  registered count
CARRY  output  1  combinational: Enable & Up & !Down & !LD & COUNT==MAX
BORROW  output  1  combinational: Enable & Down & !Up & !LD & COUNT==MIN
LD_ERR  output  1  registered one-cycle pulse: the last load was out of range and was clamped

Behaviour:
- Clr low (asynchronous, any time, including mid-load): COUNT=RESET_VAL, LD_ERR=0. The block stays held while Clr is low. The first update is at the first Clk rising edge after Clr goes high.
- All other updates occur on the Clk rising edge. Priority: LD&Enable > Up&Enable > Down&Enable > hold.
- Load:
  - COUNT = LD_VAL if MIN <= LD_VAL <= MAX.
  - If LD_VAL > MAX, COUNT = MAX and LD_ERR = 1 for one cycle.
  - If LD_VAL < MIN, COUNT = MIN and LD_ERR = 1 for one cycle.
  - Load is synchronous; LD has no asynchronous effect.
- Up only (Up=1, Down=0): COUNT = MAX ? MIN : COUNT+1.
- Down only (Up=0, Down=1): COUNT = MIN ? MAX : COUNT-1.
- Up=1 and Down=1 without LD: hold. CARRY=0, BORROW=0.
- Enable=0: hold regardless of LD, Up and Down. CARRY=0, BORROW=0.
- LD_ERR is 0 on every cycle that is not a clamped load.
- Out-of-range COUNT cannot occur in normal operation. If it does (e.g. after an X or a fault), it is corrected on the next enabled edge: Up gives MIN, Down gives MAX. Load behaves normally.
- Arithmetic is done at WIDTH+1 bits internally, so a range with MAX = 2^WIDTH-1 never overflows silently.
- Latency: COUNT changes on the edge where the command is sampled. CARRY/BORROW are valid in the same cycle as the condition, so a cascaded stage increments on the same edge as the wrap.

Optional Feature:
MOD_COUNTER_BCD_EN
- Defined:
  - Adds output port BCD_OUT of width 4*ceil(log10(MAX+1)).
  - BCD_OUT is a registered BCD image of COUNT with one cycle of latency after COUNT.
  - It resets to the BCD of RESET_VAL on Clr.
  - It feeds the display decoder directly.
- Undefined: the port is absent and no conversion logic exists. COUNT, CARRY, BORROW and LD_ERR behave identically in both builds.

Decomposition:
- Shared package clock_pkg holds:
  - range constants SEC_MAX=59, MIN_MAX=59, HR12_MIN=1, HR12_MAX=12, HR24_MAX=23;
  - a digit-width constant DIGIT_W=4;
  - the function bcd_digits(max) for the BCD port width.
- One sub-module, bin2bcd: double-dabble, combinational, parametrised on WIDTH. It is instantiated only under MOD_COUNTER_BCD_EN, and the register stage lives in mod_counter.

Test Plan:
- MIN=0, MAX=59. Clr low mid-count at COUNT=37, asynchronously between edges → COUNT=0 immediately, LD_ERR=0. No change until the first edge after release.
- MIN=1, MAX=12, Up held for 12 cycles from 11 → 12, 1, 2, …. CARRY=1 only during the cycle COUNT=12.
- Same instance, Down from 2 → 1, 12, 11. BORROW=1 only at COUNT=1. Up=Down=1 → hold with CARRY=BORROW=0.
- MIN=1, MAX=12, loads:
  - LD_VAL=15 → COUNT=12, LD_ERR=1 for one cycle;
  - LD_VAL=0 → COUNT=1, LD_ERR=1;
  - LD_VAL=7 → COUNT=7, LD_ERR=0;
  - LD asserted with Up asserted → load wins.
- Cascade seconds(0..59) → minutes(0..59) with minutes.Enable = seconds.CARRY, starting at 59/05 → next edge gives 0/06 on the same edge. Enable=0 freezes both stages.
- MOD_COUNTER_BCD_EN, MAX=59: load 47 → BCD_OUT=8'h47 one cycle after COUNT=47. Reset → BCD of RESET_VAL.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the alarm-clock digit counters.
package clock_pkg;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HR12_MIN = 1;
  localparam int unsigned HR12_MAX = 12;
  localparam int unsigned HR24_MAX = 23;
  localparam int unsigned DIGIT_W  = 4;

  // Number of decimal digits needed to show values up to max (at least one).
  function automatic int unsigned bcd_digits(input int unsigned max);
    int unsigned n;
    int unsigned v;
    n = 1;
    v = max;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/mod_counter_bin2bcd.sv
// Combinational double-dabble binary to packed-BCD converter.
module bin2bcd
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic [WIDTH-1:0]          bin,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;

  logic [BCD_W-1:0] acc;

  // Adjust each digit before shifting in the next binary bit, MSB first.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (acc[DIGIT_W*d +: DIGIT_W] >= DIGIT_W'(5))
          acc[DIGIT_W*d +: DIGIT_W] = acc[DIGIT_W*d +: DIGIT_W] + DIGIT_W'(3);
      end
      acc = {acc[BCD_W-2:0], bin[WIDTH-1-i]};
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo digit counter with clamped load and cascade carry/borrow.
// Optional registered BCD output when MOD_COUNTER_BCD_EN is defined.
module mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MIN       = 0,
  parameter int unsigned MAX       = 9,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             LD,
  input  logic [WIDTH-1:0] LD_VAL,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] COUNT,
  output logic             CARRY,
  output logic             BORROW,
`ifdef MOD_COUNTER_BCD_EN
  output logic             LD_ERR,
  output logic [DIGIT_W*bcd_digits(MAX)-1:0] BCD_OUT
`else
  output logic             LD_ERR
`endif
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   ld_x;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic             cnt_lo;
  logic             cnt_hi;
  logic             ld_lo;
  logic             ld_hi;
  logic             at_min;
  logic             at_max;
  logic [WIDTH-1:0] count_nxt;
  logic             err_nxt;

  // Range checks carry one spare bit so MAX = 2^WIDTH-1 compares correctly.
  assign cnt_x   = {1'b0, COUNT};
  assign ld_x    = {1'b0, LD_VAL};
  assign cnt_hi  = cnt_x > MAX_X;
  assign ld_hi   = ld_x > MAX_X;
  assign cnt_inc = COUNT + WIDTH'(1);
  assign cnt_dec = COUNT - WIDTH'(1);
  assign at_min  = COUNT == MIN_W;
  assign at_max  = COUNT == MAX_W;

  generate
    if (MIN == 0) begin : g_min_zero
      assign cnt_lo = 1'b0;
      assign ld_lo  = 1'b0;
    end else begin : g_min_nonzero
      assign cnt_lo = cnt_x < (WIDTH+1)'(MIN);
      assign ld_lo  = ld_x < (WIDTH+1)'(MIN);
    end
  endgenerate

  always_comb begin
    count_nxt = COUNT;
    err_nxt   = 1'b0;
    if (Enable) begin
      if (LD) begin
        if (ld_hi) begin
          count_nxt = MAX_W;
          err_nxt   = 1'b1;
        end else if (ld_lo) begin
          count_nxt = MIN_W;
          err_nxt   = 1'b1;
        end else begin
          count_nxt = LD_VAL;
        end
      end else if (Up && !Down) begin
        // An out-of-range count recovers to MIN on an up step.
        count_nxt = (at_max || cnt_hi || cnt_lo) ? MIN_W : cnt_inc;
      end else if (Down && !Up) begin
        count_nxt = (at_min || cnt_lo || cnt_hi) ? MAX_W : cnt_dec;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      COUNT  <= RST_W;
      LD_ERR <= 1'b0;
    end else begin
      COUNT  <= count_nxt;
      LD_ERR <= err_nxt;
    end
  end

  assign CARRY  = Enable & Up & ~Down & ~LD & at_max;
  assign BORROW = Enable & Down & ~Up & ~LD & at_min;

`ifdef MOD_COUNTER_BCD_EN
  localparam int unsigned DIGITS = bcd_digits(MAX);
  localparam int unsigned BCD_W  = DIGIT_W * DIGITS;

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned val);
    logic [BCD_W-1:0] r;
    int unsigned      v;
    r = '0;
    v = val;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[DIGIT_W*d +: DIGIT_W] = DIGIT_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [BCD_W-1:0] BCD_RST = to_bcd(RESET_VAL);

  logic [BCD_W-1:0] bcd_nxt;

  bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .bin (COUNT),
    .bcd (bcd_nxt)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) BCD_OUT <= BCD_RST;
    else      BCD_OUT <= bcd_nxt;
  end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: 12-hour digit, seconds->minutes cascade,
// and the BCD image when MOD_COUNTER_BCD_EN is defined.
module tb_mod_counter;

  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 12-hour digit: range 1..12, reset to 12
  logic       h_en, h_ld, h_up, h_dn;
  logic [3:0] h_ldv, h_cnt;
  logic       h_cy, h_bw, h_err;
  // seconds 0..59
  logic       s_en, s_ld, s_up, s_dn;
  logic [5:0] s_ldv, s_cnt;
  logic       s_cy, s_bw, s_err;
  // minutes 0..59, enabled by the seconds carry (or a forced enable for preload)
  logic       m_frc, m_ld, m_up, m_dn, m_en;
  logic [5:0] m_ldv, m_cnt;
  logic       m_cy, m_bw, m_err;

  assign m_en = s_cy | m_frc;

  mod_counter #(.WIDTH(4), .MIN(1), .MAX(12), .RESET_VAL(12)) u_hr (
    .Clk(Clk), .Clr(Clr), .Enable(h_en), .LD(h_ld), .LD_VAL(h_ldv), .Up(h_up), .Down(h_dn),
    .COUNT(h_cnt), .CARRY(h_cy), .BORROW(h_bw), .LD_ERR(h_err));

  mod_counter #(.WIDTH(6), .MIN(0), .MAX(59), .RESET_VAL(0)) u_sec (
    .Clk(Clk), .Clr(Clr), .Enable(s_en), .LD(s_ld), .LD_VAL(s_ldv), .Up(s_up), .Down(s_dn),
    .COUNT(s_cnt), .CARRY(s_cy), .BORROW(s_bw), .LD_ERR(s_err));

  mod_counter #(.WIDTH(6), .MIN(0), .MAX(59), .RESET_VAL(0)) u_min (
    .Clk(Clk), .Clr(Clr), .Enable(m_en), .LD(m_ld), .LD_VAL(m_ldv), .Up(m_up), .Down(m_dn),
    .COUNT(m_cnt), .CARRY(m_cy), .BORROW(m_bw), .LD_ERR(m_err));

`ifdef MOD_COUNTER_BCD_EN
  logic [5:0] b_cnt;
  logic       b_cy, b_bw, b_err;
  logic [7:0] b_bcd;
  mod_counter #(.WIDTH(6), .MIN(0), .MAX(59), .RESET_VAL(23)) u_bcd (
    .Clk(Clk), .Clr(Clr), .Enable(s_en), .LD(s_ld), .LD_VAL(s_ldv), .Up(s_up), .Down(s_dn),
    .COUNT(b_cnt), .CARRY(b_cy), .BORROW(b_bw), .LD_ERR(b_err), .BCD_OUT(b_bcd));
`endif

  // ---------------- behavioural model ----------------
  function automatic int step(input int c, input int lo, input int hi, input bit en,
                              input bit ld, input int ldv, input bit up, input bit dn,
                              output bit err);
    int r;
    r   = hi - lo + 1;
    err = 1'b0;
    if (!en) return c;
    if (ld) begin
      if (ldv > hi) begin err = 1'b1; return hi; end
      if (ldv < lo) begin err = 1'b1; return lo; end
      return ldv;
    end
    if (up && !dn) return (c < lo || c > hi) ? lo : lo + (c - lo + 1) % r;
    if (dn && !up) return (c < lo || c > hi) ? hi : lo + (c - lo + r - 1) % r;
    return c;
  endfunction

  function automatic bit carry_of(input int c, input int hi, input bit en, input bit ld,
                                  input bit up, input bit dn);
    return en && up && !dn && !ld && (c == hi);
  endfunction

  function automatic bit borrow_of(input int c, input int lo, input bit en, input bit ld,
                                   input bit up, input bit dn);
    return en && dn && !up && !ld && (c == lo);
  endfunction

  function automatic int bcd_of(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  int mh = 12, ms = 0, mm = 0;
  bit eh, es, em;
`ifdef MOD_COUNTER_BCD_EN
  int mb = 23, mbcd = 'h23;
  bit eb;
`endif

  always @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mh = 12; ms = 0; mm = 0; eh = 0; es = 0; em = 0;
`ifdef MOD_COUNTER_BCD_EN
      mb = 23; mbcd = bcd_of(23); eb = 0;
`endif
    end else begin
      bit sc;
      sc = carry_of(ms, 59, s_en, s_ld, s_up, s_dn);
`ifdef MOD_COUNTER_BCD_EN
      mbcd = bcd_of(mb);
      mb   = step(mb, 0, 59, s_en, s_ld, s_ldv, s_up, s_dn, eb);
`endif
      mh = step(mh, 1, 12, h_en, h_ld, h_ldv, h_up, h_dn, eh);
      mm = step(mm, 0, 59, sc | m_frc, m_ld, m_ldv, m_up, m_dn, em);
      ms = step(ms, 0, 59, s_en, s_ld, s_ldv, s_up, s_dn, es);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("cmp_h_count",  h_cnt, mh);
    chk("cmp_h_carry",  h_cy,  carry_of(mh, 12, h_en, h_ld, h_up, h_dn));
    chk("cmp_h_borrow", h_bw,  borrow_of(mh, 1, h_en, h_ld, h_up, h_dn));
    chk("cmp_h_lderr",  h_err, eh);
    chk("cmp_s_count",  s_cnt, ms);
    chk("cmp_s_carry",  s_cy,  carry_of(ms, 59, s_en, s_ld, s_up, s_dn));
    chk("cmp_s_borrow", s_bw,  borrow_of(ms, 0, s_en, s_ld, s_up, s_dn));
    chk("cmp_s_lderr",  s_err, es);
    chk("cmp_m_count",  m_cnt, mm);
    chk("cmp_m_lderr",  m_err, em);
`ifdef MOD_COUNTER_BCD_EN
    chk("cmp_b_count",  b_cnt, mb);
    chk("cmp_b_bcd",    b_bcd, mbcd);
    chk("cmp_b_lderr",  b_err, eb);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drv_h(input bit en, input bit ld, input int ldv, input bit up, input bit dn);
    h_en = en; h_ld = ld; h_ldv = 4'(ldv); h_up = up; h_dn = dn;
  endtask

  initial begin
    Clr = 1'b0;
    drv_h(0, 0, 0, 0, 0);
    s_en = 0; s_ld = 0; s_ldv = '0; s_up = 0; s_dn = 0;
    m_frc = 0; m_ld = 0; m_ldv = '0; m_up = 0; m_dn = 0;
    #12;
    chk("rst_h_count", h_cnt, 12);
    chk("rst_s_count", s_cnt, 0);
    chk("rst_lderr",   {h_err, s_err, m_err}, 0);
`ifdef MOD_COUNTER_BCD_EN
    chk("rst_bcd", b_bcd, 'h23);
`endif
    #1 Clr = 1'b1;

    // 12-hour up wrap
    drv_h(1, 1, 11, 0, 0); tick; chk("h_load11", h_cnt, 11);
    drv_h(1, 0, 0, 1, 0); #1 chk("h_carry_at11", h_cy, 0);
    tick; chk("h_up_12", h_cnt, 12); chk("h_carry_at12", h_cy, 1);
    tick; chk("h_wrap_1", h_cnt, 1); chk("h_carry_at1", h_cy, 0);
    repeat (10) tick;
    chk("h_up_11", h_cnt, 11);

    // 12-hour down wrap
    drv_h(1, 1, 2, 0, 0); tick; chk("h_load2", h_cnt, 2);
    drv_h(1, 0, 0, 0, 1); #1 chk("h_borrow_at2", h_bw, 0);
    tick; chk("h_down_1", h_cnt, 1); chk("h_borrow_at1", h_bw, 1);
    tick; chk("h_wrap_12", h_cnt, 12); chk("h_borrow_at12", h_bw, 0);
    tick; chk("h_down_11", h_cnt, 11);

    // Up and Down together hold, even at MAX
    drv_h(1, 1, 12, 0, 0); tick;
    drv_h(1, 0, 0, 1, 1); #1 chk("h_both_carry", h_cy, 0); chk("h_both_borrow", h_bw, 0);
    tick; chk("h_both_hold", h_cnt, 12);
    drv_h(0, 1, 5, 1, 0); #1 chk("h_dis_carry", h_cy, 0);
    tick; chk("h_dis_hold", h_cnt, 12);

    // Clamped and normal loads
    drv_h(1, 1, 15, 0, 0); tick; chk("h_ld15_count", h_cnt, 12); chk("h_ld15_err", h_err, 1);
    drv_h(1, 1, 0, 0, 0);  tick; chk("h_ld0_count", h_cnt, 1);   chk("h_ld0_err", h_err, 1);
    drv_h(1, 1, 7, 0, 0);  tick; chk("h_ld7_count", h_cnt, 7);   chk("h_ld7_err", h_err, 0);
    drv_h(1, 1, 3, 1, 0);  tick; chk("h_ld_over_up", h_cnt, 3);
    drv_h(1, 1, 14, 0, 0); tick; chk("h_ld14_err", h_err, 1);
    drv_h(0, 0, 0, 0, 0);  tick; chk("h_err_pulse_end", h_err, 0); chk("h_hold12", h_cnt, 12);

    // Seconds -> minutes cascade from 59/05
    s_en = 1; s_ld = 1; s_ldv = 59; m_frc = 1; m_ld = 1; m_ldv = 5;
    tick; chk("cas_s_59", s_cnt, 59); chk("cas_m_05", m_cnt, 5);
    s_ld = 0; s_up = 1; m_frc = 0; m_ld = 0; m_up = 1;
    #1 chk("cas_s_carry", s_cy, 1);
    tick; chk("cas_s_00", s_cnt, 0); chk("cas_m_06", m_cnt, 6);
    tick; chk("cas_s_01", s_cnt, 1); chk("cas_m_hold", m_cnt, 6);
    s_ld = 1; s_ldv = 59; s_up = 0;
    tick; chk("cas_reload_59", s_cnt, 59);
    s_en = 0; s_ld = 0; s_up = 1;
    #1 chk("cas_dis_carry", s_cy, 0);
    tick; chk("cas_freeze_s", s_cnt, 59); chk("cas_freeze_m", m_cnt, 6);

`ifdef MOD_COUNTER_BCD_EN
    s_en = 1; s_ld = 1; s_ldv = 47; s_up = 0;
    tick; chk("bcd_cnt47", b_cnt, 47); chk("bcd_lag", b_bcd, 'h59);
    s_en = 0; s_ld = 0;
    tick; chk("bcd_47", b_bcd, 'h47);
`endif

    // Asynchronous clear between edges at seconds=37
    s_en = 1; s_ld = 1; s_ldv = 37; s_up = 0;
    tick; chk("ar_s_37", s_cnt, 37);
    s_ld = 0; s_up = 1;
    #2 Clr = 1'b0;
    #1 chk("ar_s_zero", s_cnt, 0); chk("ar_s_err", s_err, 0);
    chk("ar_h_rst", h_cnt, 12); chk("ar_m_rst", m_cnt, 0);
`ifdef MOD_COUNTER_BCD_EN
    chk("ar_bcd_rst", b_bcd, 'h23);
`endif
    @(posedge Clk); #1 chk("ar_held", s_cnt, 0);
    #2 Clr = 1'b1;
    #1 chk("ar_release_nochg", s_cnt, 0);
    tick; chk("ar_first_edge", s_cnt, 1);
    s_en = 0; s_up = 0;
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
